// File: rtl/hdmi_audio_feeder.sv
// Audio FIFO feeding the HDMI encoder. A fractional accumulator releases samples at RATE_HZ, one cycle after each tick.
// Pushes while full are dropped and set the sticky overflow. Optional AUDIO_UNDERRUN_MUTE_EN sends silence on underrun.
module hdmi_audio_feeder #(
   parameter int CLK_HZ     = 74250000,
   parameter int RATE_HZ    = 48000,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [31:0]           wr_data,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [15:0]           underrun_cnt,
   output logic                  audio_w,
   output logic [31:0]           audio
);

   localparam logic [31:0]         STEP_UP = 32'(RATE_HZ);
   localparam logic [31:0]         STEP_DN = 32'(RATE_HZ - CLK_HZ);
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

   logic [31:0]         d;
   logic                tick;
   logic [DEPTH_LOG2:0] wptr;
   logic [DEPTH_LOG2:0] rptr;
   logic [31:0]         mem [0:(2**DEPTH_LOG2)-1];
   logic [31:0]         last;
   logic                empty;
   logic                push;
   logic                pop;

   assign tick  = ~d[31] & enable;
   assign level = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                  (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
   assign push  = wr & ~full;
   assign pop   = tick & ~empty;

   // Free-running: the sign of d decides whether this cycle owes a sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) d <= '0;
      else       d <= d + (d[31] ? STEP_UP : STEP_DN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)      wptr     <= wptr + PTR_ONE;
         if (pop)       rptr     <= rptr + PTR_ONE;
         if (wr & full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         audio_w      <= 1'b0;
         audio        <= '0;
         last         <= '0;
         underrun_cnt <= '0;
      end else begin
         audio_w <= tick;
         if (pop) begin
            audio <= mem[rptr[DEPTH_LOG2-1:0]];
            last  <= mem[rptr[DEPTH_LOG2-1:0]];
         end else if (tick) begin
`ifdef AUDIO_UNDERRUN_MUTE_EN
            audio <= '0;
            last  <= '0;
`else
            audio <= last;
`endif
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_audio_feeder.sv
// Directed plus random bench for hdmi_audio_feeder, scored against a queue-based model whose tick schedule comes from floor(n*R/C).
module tb_hdmi_audio_feeder;
   localparam int C     = 10;
   localparam int R     = 3;
   localparam int DL    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          wr = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          full;
   logic [DL:0]   level;
   logic          overflow;
   logic [15:0]   underrun_cnt;
   logic          audio_w;
   logic [31:0]   audio;

   hdmi_audio_feeder #(.CLK_HZ(C), .RATE_HZ(R), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .reset(reset), .enable(enable), .wr(wr), .wr_data(wr_data),
      .full(full), .level(level), .overflow(overflow), .underrun_cnt(underrun_cnt),
      .audio_w(audio_w), .audio(audio)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] q[$];
   logic [31:0] m_audio;
   logic [31:0] m_last;
   logic        m_audio_w;
   logic        m_ovf;
   int          m_ucnt;
   longint      cyc;

   // Cycle n (counted from reset release) owes a sample when floor(n*R/C) steps up.
   function automatic bit tick_abs(input longint n);
      if (n == 0) return 1'b1;
      return ((n * R) / C) != (((n - 1) * R) / C);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_audio = '0; m_last = '0; m_audio_w = 1'b0; m_ovf = 1'b0; m_ucnt = 0; cyc = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".audio_w"}, 32'(audio_w), 32'(m_audio_w));
      check({tag, ".audio"}, audio, m_audio);
      check({tag, ".level"}, 32'(level), 32'(q.size()));
      check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".underrun_cnt"}, 32'(underrun_cnt), 32'(m_ucnt));
   endtask

   task automatic step(input bit en, input bit w, input logic [31:0] dat);
      bit t, full_m;
      enable = en; wr = w; wr_data = dat;
      t = tick_abs(cyc) && en;
      full_m = (q.size() == DEPTH);
      m_audio_w = t;
      if (t) begin
         if (q.size() != 0) begin
            m_audio = q.pop_front();
            m_last  = m_audio;
         end else begin
`ifdef AUDIO_UNDERRUN_MUTE_EN
            m_audio = '0;
            m_last  = '0;
`else
            m_audio = m_last;
`endif
            if (m_ucnt < 65535) m_ucnt++;
         end
      end
      if (w) begin
         if (!full_m) q.push_back(dat);
         else         m_ovf = 1'b1;
      end
      cyc++;
      @(posedge clk); #1;
      check_all("step");
   endtask

   task automatic do_reset();
      enable = 1'b0; wr = 1'b0;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      #1;
      reset = 1'b0;
   endtask

   int pulses;
   int gap;
   int last_pulse;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // Empty FIFO: seven underruns in cycles 0..21.
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0, '0);
      check("t1_ucnt", 32'(underrun_cnt), 32'd7);

      // Two samples then an underrun repeat (or silence).
      do_reset();
      step(1'b0, 1'b1, 32'h22221111);
      step(1'b0, 1'b1, 32'h44443333);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
`ifdef AUDIO_UNDERRUN_MUTE_EN
      check("t2_audio", audio, 32'h00000000);
`else
      check("t2_audio", audio, 32'h44443333);
`endif
      check("t2_ucnt", 32'(underrun_cnt), 32'd1);

      // Fill past capacity while disabled, then drain.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom);
      check("t3_full", 32'(full), 32'd1);
      check("t3_level", 32'(level), 32'd4);
      check("t3_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0);

      // Push into a full FIFO on a tick cycle: pop wins, push dropped.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom);
      check("t4_pre_ovf", 32'(overflow), 32'd0);
      step(1'b1, 1'b1, 32'hDEADBEEF);
      check("t4_level", 32'(level), 32'd3);
      check("t4_ovf", 32'(overflow), 32'd1);

      // Rate and spacing with the FIFO kept fed.
      do_reset();
      pulses = 0; last_pulse = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, level < 3'd2, $urandom);
         if (audio_w) begin
            if (last_pulse >= 0) begin
               gap = i - last_pulse;
               check("t5_gap", 32'(gap == 3 || gap == 4), 32'd1);
            end
            last_pulse = i;
            pulses++;
         end
      end
      check("t5_pulses", 32'(pulses), 32'd9);

      // Reset mid-stream with level=3 and five underruns recorded.
      do_reset();
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom);
      check("t6_pre_level", 32'(level), 32'd3);
      check("t6_pre_ucnt", 32'(underrun_cnt), 32'd5);
      do_reset();
      step(1'b1, 1'b0, '0);
      check("t6_first_tick", 32'(audio_w), 32'd1);
      check("t6_audio", audio, 32'd0);
      check("t6_ucnt", 32'(underrun_cnt), 32'd1);

      // Random traffic: heavy pushing, then light pushing.
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom);
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
